// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply and radix-2 restoring divide over XLEN iterations.
// Divide-by-zero and signed overflow resolve in one cycle without iterating.
// Optional build macro MULDIV_FAST_MUL_EN: single-cycle combinational multiply.
module ex_muldiv_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned PW = 2 * XLEN;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;

    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [CNT_W-1:0] cnt;
    logic [PW-1:0]    acc;        // multiply: {partial hi, multiplier}; divide: {remainder, dividend/quotient}
    logic [XLEN-1:0]  opnd;       // multiplicand or divisor magnitude
    logic [2:0]       op_q;
    logic             neg_q;      // product/quotient negation
    logic             neg_r;      // remainder takes dividend sign

    logic             load;
    logic             spec_ld;
    logic             step;

    logic             is_div;
    logic             signed_a;
    logic             signed_b;
    logic [XLEN-1:0]  a_mag;
    logic [XLEN-1:0]  b_mag;
    logic             div_zero;
    logic             div_ovf;
    logic             fast_hit;
    logic [XLEN-1:0]  fast_res;
    logic             special;
    logic [XLEN-1:0]  spec_res;

    logic [XLEN:0]    mul_sum;
    logic [PW-1:0]    mul_next;
    logic [XLEN:0]    rem_shift;
    logic [XLEN:0]    div_diff;
    logic [PW-1:0]    div_next;
    logic [PW-1:0]    acc_next;
    logic [PW-1:0]    prod_fix;
    logic [XLEN-1:0]  quot_fix;
    logic [XLEN-1:0]  rem_fix;
    logic [XLEN-1:0]  fin_res;

    // Operand decode, magnitudes and one-cycle special-case detection
    always_comb begin
        is_div   = op[2];
        signed_a = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        signed_b = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        a_mag    = (signed_a && rs1_data[XLEN-1]) ? -rs1_data : rs1_data;
        b_mag    = (signed_b && rs2_data[XLEN-1]) ? -rs2_data : rs2_data;
        div_zero = is_div && (rs2_data == '0);
        div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (rs1_data == MIN_NEG) && (rs2_data == ALL_ONES);
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [PW-1:0] fast_a;
    logic [PW-1:0] fast_b;
    logic [PW-1:0] fast_prod;

    // Sign-extended operands; the low PW bits of the product are exact for any signedness
    always_comb begin
        fast_a    = {{XLEN{signed_a & rs1_data[XLEN-1]}}, rs1_data};
        fast_b    = {{XLEN{signed_b & rs2_data[XLEN-1]}}, rs2_data};
        fast_prod = fast_a * fast_b;
        fast_hit  = !is_div;
        fast_res  = (op == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[PW-1:XLEN];
    end
`else
    // Multiplies always iterate in this build
    always_comb begin
        fast_hit = 1'b0;
        fast_res = '0;
    end
`endif

    // Result for ops that finish straight from IDLE
    always_comb begin
        special  = fast_hit || div_zero || div_ovf;
        spec_res = '0;
        if (fast_hit) begin
            spec_res = fast_res;
        end else begin
            case (op)
                OP_DIV:  spec_res = div_zero ? ALL_ONES : MIN_NEG;
                OP_DIVU: spec_res = ALL_ONES;
                OP_REM:  spec_res = div_zero ? rs1_data : '0;
                default: spec_res = rs1_data;
            endcase
        end
    end

    // One radix-2 iteration plus sign correction of the final value
    always_comb begin
        mul_sum   = {1'b0, acc[PW-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next  = {mul_sum, acc[XLEN-1:1]};
        rem_shift = {acc[PW-1:XLEN], acc[XLEN-1]};
        div_diff  = rem_shift - {1'b0, opnd};
        div_next  = div_diff[XLEN] ? {rem_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        acc_next  = op_q[2] ? div_next : mul_next;
        prod_fix  = neg_q ? -acc_next : acc_next;
        quot_fix  = neg_q ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
        rem_fix   = neg_r ? -acc_next[PW-1:XLEN] : acc_next[PW-1:XLEN];
        case (op_q)
            OP_MUL:                       fin_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod_fix[PW-1:XLEN];
            OP_DIV, OP_DIVU:              fin_res = quot_fix;
            default:                      fin_res = rem_fix;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_next = state;
        load       = 1'b0;
        spec_ld    = 1'b0;
        step       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !flush) begin
                    if (special) begin
                        spec_ld    = 1'b1;
                        state_next = S_DONE;
                    end else begin
                        load       = 1'b1;
                        state_next = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (flush) begin
                    state_next = S_IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt == '0) begin
                        state_next = S_DONE;
                    end
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Pipeline pause request; must not depend on the pause path itself
    assign stall = !rst && (((state == S_IDLE) && start && !flush) || (state == S_BUSY));

    // Operand latch, iteration and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= (state_next == S_DONE);
            if (load) begin
                op_q  <= op;
                cnt   <= CNT_W'(XLEN - 1);
                neg_q <= (signed_a & rs1_data[XLEN-1]) ^ (signed_b & rs2_data[XLEN-1]);
                neg_r <= signed_a & rs1_data[XLEN-1];
                acc   <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
                opnd  <= is_div ? b_mag : a_mag;
            end
            if (spec_ld) begin
                result <= spec_res;
            end
            if (step) begin
                acc <= acc_next;
                cnt <= cnt - CNT_W'(1);
                if (cnt == '0) begin
                    result <= fin_res;
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed-vector bench for ex_muldiv_unit.
// Honours MULDIV_FAST_MUL_EN for expected multiply latency.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    always #5 clk = ~clk;

    ex_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .start    (start),
        .op       (op),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .stall    (stall),
        .done     (done),
        .result   (result)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Start an op at cycle T, hold start until done, check result, latency and stall count
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int  k;
        int  stalls;
        int  lat;
        bit  seen;
        @(posedge clk); #1;
        op = o; rs1_data = a; rs2_data = b; start = 1'b1;
        k = 0; stalls = 0; lat = -1; seen = 1'b0;
        while (!seen && k < 60) begin
            #1;
            if (stall) stalls++;
            if (done) begin
                seen = 1'b1;
                lat  = k;
            end
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        #1;
        check({tag, ":res"}, result, exp);
        check({tag, ":lat"}, 32'(lat), 32'(exp_lat));
        check({tag, ":stall"}, 32'(stalls), 32'(exp_lat));
        check({tag, ":single"}, {31'b0, done}, 32'd0);
    endtask

    // Count done pulses over n cycles
    task automatic count_done(input int n, output int dones);
        dones = 0;
        repeat (n) begin
            @(posedge clk); #2;
            if (done) dones++;
        end
    endtask

    initial begin
        int dones;
        logic [31:0] held;

        rst = 1'b1; flush = 1'b0; start = 1'b1; op = 3'd0;
        rs1_data = 32'd1; rs2_data = 32'd1;
        repeat (3) @(posedge clk);
        #1;
        check("rst:stall", {31'b0, stall}, 32'd0);
        check("rst:done", {31'b0, done}, 32'd0);
        check("rst:result", result, 32'd0);
        rst = 1'b0; start = 1'b0;

        run_op("mul",      3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT);
        run_op("mulh",     3'd1, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT);
        run_op("mulhu",    3'd3, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT);
        run_op("mulhsu",   3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, MUL_LAT);
        run_op("mulh_m1",  3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MUL_LAT);
        run_op("mulhu_m1", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
        run_op("divu",     3'd5, 32'd100,      32'd7,        32'd14,       DIV_LAT);
        run_op("remu",     3'd7, 32'd100,      32'd7,        32'd2,        DIV_LAT);
        run_op("div_neg",  3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DIV_LAT);
        run_op("rem_neg",  3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DIV_LAT);
        run_op("div_nn",   3'd4, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        DIV_LAT);
        run_op("divu_z",   3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
        run_op("rem_z",    3'd6, 32'd5,        32'd0,        32'd5,        1);
        run_op("div_ovf",  3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_op("rem_ovf",  3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

        // flush together with start in IDLE: not accepted
        @(posedge clk); #1;
        op = 3'd5; rs1_data = 32'd100; rs2_data = 32'd7; start = 1'b1; flush = 1'b1;
        #1;
        check("idle_flush:stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        #1;
        check("idle_flush:busy", {31'b0, stall}, 32'd0);

        // flush in the middle of a divide
        run_op("divu_pre", 3'd5, 32'd50, 32'd6, 32'd8, DIV_LAT);
        held = result;
        @(posedge clk); #1;
        op = 3'd4; rs1_data = 32'd100; rs2_data = 32'd7; start = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1;
        #1;
        check("flush:busy_stall", {31'b0, stall}, 32'd1);
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        #1;
        check("flush:stall", {31'b0, stall}, 32'd0);
        check("flush:done", {31'b0, done}, 32'd0);
        count_done(40, dones);
        check("flush:no_done", 32'(dones), 32'd0);
        check("flush:held", result, held);
        run_op("div_after", 3'd4, 32'd100, 32'd7, 32'd14, DIV_LAT);

        // reset in the middle of a divide
        @(posedge clk); #1;
        op = 3'd5; rs1_data = 32'd1000; rs2_data = 32'd3; start = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        #1;
        check("rstmid:result", result, 32'd0);
        check("rstmid:stall", {31'b0, stall}, 32'd0);
        check("rstmid:done", {31'b0, done}, 32'd0);
        count_done(40, dones);
        check("rstmid:no_done", 32'(dones), 32'd0);
        run_op("remu_after", 3'd7, 32'd1000, 32'd3, 32'd1, DIV_LAT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes operands and the funct3-coded op from ID/EX when the decoded instruction is M-extension.
- Drives a stall request back to the pause inputs of IF/ID and ID/EX while computing.
- Presents a one-cycle done/result to the EX result mux for capture into EX/MEM.

Parameters:
- XLEN, 32, operand/result width (only 32 supported for RV32M encoding rules).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  EX-stage flush (branch/jump taken); aborts operation
- start  in  1  ID/EX holds a valid M-extension op
- op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rs1_data  in  XLEN  dividend / multiplicand
- rs2_data  in  XLEN  divisor / multiplier
- stall  out  1  pipeline pause request
- done  out  1  result valid, exactly one cycle
- result  out  XLEN  final result, held until next accepted start

Behaviour:
- Reset: state IDLE; done=0; result=0; counter=0; internal accumulators=0; stall=0 (reset dominates all other inputs).
- States: IDLE, BUSY, DONE.
- stall = (IDLE & start & ~flush) | BUSY. Combinational and registered-state only; has no dependency on the pause path.
- IDLE -> BUSY on start & ~flush & ~special.
  - Latch op and sign flags.
  - Latch |rs1| and |rs2| for signed ops (MULHSU: rs1 signed, rs2 unsigned).
  - Load counter = XLEN-1.
- IDLE -> DONE on start & ~flush & special. Special cases:
  - Divide by zero (div ops, rs2==0): DIV/DIVU -> all ones; REM/REMU -> rs1.
  - Signed overflow (DIV/REM, rs1==0x80000000, rs2==0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
  - Result written at the IDLE->DONE transition.
- BUSY, one iteration per cycle:
  - Multiply: radix-2 shift-add into a 2*XLEN product.
  - Divide: radix-2 restoring, shift remainder left by 1, subtract divisor, set quotient bit if non-negative.
  - Counter decrements. At counter==0 -> DONE.
  - On that transition, sign-correct (negate the 2*XLEN product if signs differ; quotient negated if signs differ; remainder takes dividend sign) and register the result.
- Result selection:
  - MUL -> low XLEN.
  - MULH/MULHSU/MULHU -> high XLEN.
  - DIV/DIVU -> quotient.
  - REM/REMU -> remainder.
- DONE: done=1, stall=0. Always -> IDLE next cycle.
  - start is ignored in DONE; it is still high from the held ID/EX, and must not re-trigger.
- Latency:
  - Start accepted at cycle T: stall high T..T+XLEN, done at T+XLEN+1.
  - Special case: stall high at T only, done at T+1.
- flush:
  - In BUSY -> IDLE next cycle; no done pulse; result unchanged.
  - In IDLE with start -> not accepted.
  - In DONE -> done still pulses; EX/MEM flush discards it.
- rst mid-BUSY -> IDLE; no done pulse; result cleared.
- No arithmetic wraps out of the 2*XLEN product. Counter never underflows because exit is at 0.

Optional Feature:
- MULDIV_FAST_MUL_EN
- Defined:
  - Multiply ops use a single-cycle combinational XLEN x XLEN signed/unsigned product.
  - IDLE -> DONE directly for all multiplies; stall high 1 cycle, done at T+1.
  - Divide path unchanged.
- Undefined: all multiplies use the iterative BUSY path, XLEN+1 cycle latency.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3) -> stall high 33 cycles, done at T+33, result 0xFFFFFFEB. Fast-mul build: done at T+1.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM 0xFFFFFFF9/2 -> 0xFFFFFFFF.
- DIVU 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0. Each: done at T+1, stall 1 cycle.
- Start DIV, assert flush at T+10 -> IDLE at T+11, no done, stall low; then start is accepted again normally.
- Hold start high through DONE (pause-held ID/EX) -> exactly one done pulse. Assert rst at T+5 -> result 0, no done.
